// File: rtl/tap_line_pkg.sv
// Shared sizing helpers and constants for the multi-channel tap delay line.
// Widths are derived here so the top and the pointer sub-module agree on them.
package tap_line_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int aw_of(input int depth);
        return clog2(depth);
    endfunction

    // A single channel still needs a one-bit select port.
    function automatic int cw_of(input int nch);
        return (nch > 1) ? clog2(nch) : 1;
    endfunction

    function automatic int maw_of(input int nch, input int depth);
        return clog2(nch * depth);
    endfunction

    localparam logic ZERO_PAD_BIT = 1'b0;

endpackage

// File: rtl/tap_line_ptr.sv
// Per-channel write pointer and saturating fill count for the tap delay line.
// The fill count gates stale memory, so a flush only needs to reset this state.
module tap_line_ptr
    import tap_line_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   we,
    output logic [aw_of(DEPTH)-1:0] wptr,
    output logic [aw_of(DEPTH):0]   fill,
    output logic                   primed
);

    localparam int AW = aw_of(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   fill_q, fill_d;

    always_comb begin
        wptr_d = wptr_q;
        fill_d = fill_q;
        if (clr) begin
            wptr_d = '0;
            fill_d = '0;
        end else if (we) begin
            wptr_d = wptr_q + AW'(1);
            if (fill_q != FULL) begin
                fill_d = fill_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            fill_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            fill_q <= fill_d;
        end
    end

    assign wptr   = wptr_q;
    assign fill   = fill_q;
    assign primed = (fill_q == FULL);

endmodule

// File: rtl/tap_line_ring.sv
// Multi-channel circular-buffer sample delay line with one registered tap read port.
// Taps are addressed by age; taps older than the channel's fill count read as zero.
module tap_line_ring
    import tap_line_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int NCH   = 2
) (
    input  logic                    clk,
    input  logic                    R,
    input  logic                    clr,
    input  logic                    E,
    input  logic [cw_of(NCH)-1:0]   ch_w,
    input  logic [WIDTH-1:0]        w,
    input  logic                    rd,
    input  logic [cw_of(NCH)-1:0]   ch_r,
    input  logic [aw_of(DEPTH)-1:0] Addr,
    output logic [WIDTH-1:0]        Q,
    output logic                    Q_valid,
    output logic [NCH-1:0]          primed
);

    localparam int AW  = aw_of(DEPTH);
    localparam int CW  = cw_of(NCH);
    localparam int MAW = (maw_of(NCH, DEPTH) > 0) ? maw_of(NCH, DEPTH) : 1;

    logic [WIDTH-1:0] mem [NCH*DEPTH];

    logic [NCH-1:0] we;
    logic [AW-1:0]  wptr [NCH];
    logic [AW:0]    fill [NCH];

    logic           wr_en;
    logic [MAW-1:0] wr_idx;
    logic           rd_ch_ok;
    logic [AW-1:0]  rd_wptr;
    logic [AW:0]    rd_fill;
    logic [MAW-1:0] rd_base;
    logic [AW-1:0]  rd_slot;
    logic [MAW-1:0] rd_idx;
    logic           rd_live;

    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;

    // Unmatched (out-of-range) write channels leave every strobe low.
    always_comb begin
        we = '0;
        for (int c = 0; c < NCH; c++) begin
            we[c] = E && !clr && (ch_w == CW'(c));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tap_line_ptr #(
            .DEPTH (DEPTH)
        ) u_ptr (
            .clk    (clk),
            .rst_n  (R),
            .clr    (clr),
            .we     (we[g]),
            .wptr   (wptr[g]),
            .fill   (fill[g]),
            .primed (primed[g])
        );
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = '0;
        rd_ch_ok = 1'b0;
        rd_wptr  = '0;
        rd_fill  = '0;
        rd_base  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (we[c]) begin
                wr_en  = 1'b1;
                wr_idx = MAW'(c * DEPTH + int'(wptr[c]));
            end
            if (ch_r == CW'(c)) begin
                rd_ch_ok = 1'b1;
                rd_wptr  = wptr[c];
                rd_fill  = fill[c];
                rd_base  = MAW'(c * DEPTH);
            end
        end
    end

    // Reads see pre-write pointer state, so a same-cycle write stays invisible.
    always_comb begin
        rd_slot = rd_wptr - AW'(1) - Addr;
        rd_idx  = rd_base + MAW'(rd_slot);
        rd_live = rd_ch_ok && ({1'b0, Addr} < rd_fill);
    end

    always_comb begin
        q_d       = q_q;
        q_valid_d = rd;
        if (rd) begin
            q_d = rd_live ? mem[rd_idx] : {WIDTH{ZERO_PAD_BIT}};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= w;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign Q       = q_q;
    assign Q_valid = q_valid_q;

endmodule

// File: tb/tb_tap_line_ring.sv
// Self-checking bench for tap_line_ring: directed scenarios plus random traffic
// compared against a per-channel history-queue model of the delay line.
module tb_tap_line_ring;

   localparam int WIDTH = 16;
   localparam int DEPTH = 64;
   localparam int NCH   = 2;

   logic             clk = 1'b0;
   logic             R;
   logic             clr;
   logic             E;
   logic [0:0]       ch_w;
   logic [WIDTH-1:0] w;
   logic             rd;
   logic [0:0]       ch_r;
   logic [5:0]       Addr;
   logic [WIDTH-1:0] Q;
   logic             Q_valid;
   logic [NCH-1:0]   primed;

   int nChecks = 0;
   int nFails  = 0;

   // Model: samples written since the last flush/reset, oldest first, newest last.
   int hist0[$];
   int hist1[$];
   int expQ     = 0;
   bit expValid = 1'b0;

   tap_line_ring #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .NCH   (NCH)
   ) dut (
      .clk     (clk),
      .R       (R),
      .clr     (clr),
      .E       (E),
      .ch_w    (ch_w),
      .w       (w),
      .rd      (rd),
      .ch_r    (ch_r),
      .Addr    (Addr),
      .Q       (Q),
      .Q_valid (Q_valid),
      .primed  (primed)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Compare one observed value against the model and tally the result.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Tap of age a in channel ch: zero once the age exceeds what has been written.
   function automatic int modelRead(input int ch, input int a);
      int n;
      n = (ch == 0) ? hist0.size() : hist1.size();
      if (a >= n) return 0;
      return (ch == 0) ? hist0[n-1-a] : hist1[n-1-a];
   endfunction

   // Push a sample, keeping only the last DEPTH of them.
   task automatic modelPush(input int ch, input int v);
      if (ch == 0) begin
         hist0.push_back(v);
         if (hist0.size() > DEPTH) void'(hist0.pop_front());
      end else begin
         hist1.push_back(v);
         if (hist1.size() > DEPTH) void'(hist1.pop_front());
      end
   endtask

   function automatic logic [31:0] expPrimed();
      logic [31:0] p;
      p = '0;
      p[0] = (hist0.size() == DEPTH);
      p[1] = (hist1.size() == DEPTH);
      return p;
   endfunction

   // Drive one cycle of inputs, advance the model at the edge and check every output.
   task automatic applyStimulus(input string label, input bit e, input int chw, input int wv,
                                input bit r, input int chr, input int a, input bit c);
      @(negedge clk);
      E    = e;
      ch_w = chw[0:0];
      w    = wv[WIDTH-1:0];
      rd   = r;
      ch_r = chr[0:0];
      Addr = a[5:0];
      clr  = c;
      @(posedge clk);
      if (r) begin
         expQ     = modelRead(chr, a);
         expValid = 1'b1;
      end else begin
         expValid = 1'b0;
      end
      if (c) begin
         hist0.delete();
         hist1.delete();
      end else if (e) begin
         modelPush(chw, wv & 32'hFFFF);
      end
      #1;
      checkOutput({label, ".Q"}, 32'(Q), 32'(expQ));
      checkOutput({label, ".Q_valid"}, 32'(Q_valid), 32'(expValid));
      checkOutput({label, ".primed"}, 32'(primed), expPrimed());
   endtask

   initial begin
      R = 1'b0; clr = 1'b0; E = 1'b0; ch_w = '0; w = '0; rd = 1'b0; ch_r = '0; Addr = '0;

      // Reset and zero padding.
      repeat (2) @(posedge clk);
      @(negedge clk);
      R = 1'b1;
      #1;
      checkOutput("reset.Q", 32'(Q), 32'd0);
      checkOutput("reset.Q_valid", 32'(Q_valid), 32'd0);
      checkOutput("reset.primed", 32'(primed), 32'd0);
      applyStimulus("zeroPad", 1'b0, 0, 0, 1'b1, 0, 5, 1'b0);
      checkOutput("zeroPad.Qconst", 32'(Q), 32'd0);

      // Basic taps on channel 0.
      for (int i = 1; i <= 5; i++) applyStimulus("fill0", 1'b1, 0, i, 1'b0, 0, 0, 1'b0);
      applyStimulus("tap0", 1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
      checkOutput("tap0.Qconst", 32'(Q), 32'd5);
      applyStimulus("tap4", 1'b0, 0, 0, 1'b1, 0, 4, 1'b0);
      checkOutput("tap4.Qconst", 32'(Q), 32'd1);
      applyStimulus("tap5", 1'b0, 0, 0, 1'b1, 0, 5, 1'b0);
      checkOutput("tap5.Qconst", 32'(Q), 32'd0);

      // Wrap-around on channel 1.
      for (int i = 0; i < 70; i++) applyStimulus("fill1", 1'b1, 1, i, 1'b0, 0, 0, 1'b0);
      applyStimulus("wrap0", 1'b0, 0, 0, 1'b1, 1, 0, 1'b0);
      checkOutput("wrap0.Qconst", 32'(Q), 32'd69);
      applyStimulus("wrap63", 1'b0, 0, 0, 1'b1, 1, 63, 1'b0);
      checkOutput("wrap63.Qconst", 32'(Q), 32'd6);
      checkOutput("wrap.primedConst", 32'(primed), 32'd2);
      applyStimulus("ch0Intact", 1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
      checkOutput("ch0Intact.Qconst", 32'(Q), 32'd5);

      // Same-cycle write and read on one channel.
      applyStimulus("simul", 1'b1, 0, 100, 1'b1, 0, 0, 1'b0);
      checkOutput("simul.Qconst", 32'(Q), 32'd5);
      applyStimulus("simulNext", 1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
      checkOutput("simulNext.Qconst", 32'(Q), 32'd100);

      // Flush beats a same-cycle write; the read still sees pre-flush state.
      applyStimulus("clr", 1'b1, 0, 7, 1'b1, 0, 0, 1'b0 | 1'b1);
      checkOutput("clr.Qconst", 32'(Q), 32'd100);
      applyStimulus("postClr0", 1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
      checkOutput("postClr0.Qconst", 32'(Q), 32'd0);
      applyStimulus("postClr1", 1'b0, 0, 0, 1'b1, 1, 10, 1'b0);
      checkOutput("postClr1.Qconst", 32'(Q), 32'd0);
      checkOutput("postClr.primedConst", 32'(primed), 32'd0);
      applyStimulus("wr9", 1'b1, 0, 9, 1'b0, 0, 0, 1'b0);
      applyStimulus("rd9", 1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
      checkOutput("rd9.Qconst", 32'(Q), 32'd9);

      // Asynchronous reset between edges during back-to-back writes.
      for (int i = 0; i < DEPTH + 3; i++) applyStimulus("stream", 1'b1, 0, 200 + i, 1'b1, 0, 0, 1'b0);
      #2;
      R = 1'b0;
      #1;
      checkOutput("asyncRst.Q", 32'(Q), 32'd0);
      checkOutput("asyncRst.Q_valid", 32'(Q_valid), 32'd0);
      checkOutput("asyncRst.primed", 32'(primed), 32'd0);
      hist0.delete();
      hist1.delete();
      expQ = 0;
      expValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      R = 1'b1;
      E = 1'b0;
      rd = 1'b0;
      applyStimulus("afterRst0", 1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
      checkOutput("afterRst0.Qconst", 32'(Q), 32'd0);
      applyStimulus("afterRst1", 1'b0, 0, 0, 1'b1, 1, 0, 1'b0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                       ($urandom_range(0, 149) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
